// File: rtl/pe_frame_ctrl.sv
// pe_frame_ctrl: packs a serial RGB frame into the flat buses read by the
// background-removal pe, runs its Start_Sum -> Start_BgRemoval -> Ack handshake,
// captures the processed frame and replays it as a serial RGB stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for the first pixel of a frame
// LOAD     | collecting the remaining pixels of the frame
// SUM_GO   | Start_Sum pulse
// SUM_WAIT | waiting for pe_sum_done
// BG_GO    | Start_BgRemoval pulse
// BG_WAIT  | waiting for pe_bg_done; processed frame captured when it arrives
// ACK      | Ack held until the pe drops pe_bg_done
// DRAIN    | streaming the captured frame out, one pixel per out handshake
// ERR      | pe failed to respond in time; only Reset leaves this state
module pe_frame_ctrl #(
    parameter int NUM_PIXELS = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_r,
    input  logic [7:0]              in_g,
    input  logic [7:0]              in_b,
    output logic [8*NUM_PIXELS-1:0] pe_red_in,
    output logic [8*NUM_PIXELS-1:0] pe_green_in,
    output logic [8*NUM_PIXELS-1:0] pe_blue_in,
    output logic                    Start_Sum,
    output logic                    Start_BgRemoval,
    output logic                    Ack,
    input  logic                    pe_sum_done,
    input  logic                    pe_bg_done,
    input  logic [8*NUM_PIXELS-1:0] pe_red_out,
    input  logic [8*NUM_PIXELS-1:0] pe_green_out,
    input  logic [8*NUM_PIXELS-1:0] pe_blue_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_r,
    output logic [7:0]              out_g,
    output logic [7:0]              out_b,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int CW = $clog2(NUM_PIXELS) + 1;
    localparam int IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_PIX  = CW'(NUM_PIXELS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, SUM_GO, SUM_WAIT, BG_GO, BG_WAIT, ACK, DRAIN, ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   idx;
    logic [7:0]      pack_r [NUM_PIXELS];
    logic [7:0]      pack_g [NUM_PIXELS];
    logic [7:0]      pack_b [NUM_PIXELS];
    logic [7:0]      cap_r  [NUM_PIXELS];
    logic [7:0]      cap_g  [NUM_PIXELS];
    logic [7:0]      cap_b  [NUM_PIXELS];

    // cnt never exceeds NUM_PIXELS-1 while it is used as a pixel index
    assign idx      = cnt[IW-1:0];
    assign in_ready = !Reset && (state == IDLE || state == LOAD);
    assign out_r    = cap_r[idx];
    assign out_g    = cap_g[idx];
    assign out_b    = cap_b[idx];

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pack
        assign pe_red_in[8*i +: 8]   = pack_r[i];
        assign pe_green_in[8*i +: 8] = pack_g[i];
        assign pe_blue_in[8*i +: 8]  = pack_b[i];
    end

    // Frame sequencer: state, counters, pack/capture buffers and registered handshake outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            cnt             <= '0;
            timer           <= '0;
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            Ack             <= 1'b0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                pack_r[i] <= '0;
                pack_g[i] <= '0;
                pack_b[i] <= '0;
                cap_r[i]  <= '0;
                cap_g[i]  <= '0;
                cap_b[i]  <= '0;
            end
        end else begin
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        pack_r[idx] <= in_r;
                        pack_g[idx] <= in_g;
                        pack_b[idx] <= in_b;
                        cnt         <= cnt + 1'b1;
                        busy        <= 1'b1;
                        if (cnt == LAST_PIX) begin
                            state     <= SUM_GO;
                            Start_Sum <= 1'b1;
                            timer     <= '0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                // the pulse cycle counts as the first cycle of the pe wait window
                SUM_GO: begin
                    state <= SUM_WAIT;
                    timer <= timer + 1'b1;
                end
                SUM_WAIT: begin
                    if (pe_sum_done) begin
                        state           <= BG_GO;
                        Start_BgRemoval <= 1'b1;
                        timer           <= '0;
                    end else if (timer == TIMER_MAX) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BG_GO: begin
                    state <= BG_WAIT;
                    timer <= timer + 1'b1;
                end
                BG_WAIT: begin
                    if (pe_bg_done) begin
                        for (int i = 0; i < NUM_PIXELS; i++) begin
                            cap_r[i] <= pe_red_out[8*i +: 8];
                            cap_g[i] <= pe_green_out[8*i +: 8];
                            cap_b[i] <= pe_blue_out[8*i +: 8];
                        end
                        state <= ACK;
                        Ack   <= 1'b1;
                        timer <= '0;
                    end else if (timer == TIMER_MAX) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    if (!pe_bg_done) begin
                        state     <= DRAIN;
                        Ack       <= 1'b0;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end else if (timer == TIMER_MAX) begin
                        state       <= ERR;
                        Ack         <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (cnt == LAST_PIX) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ERR: begin
                    timeout_err <= 1'b1;
                    Ack         <= 1'b0;
                    out_valid   <= 1'b0;
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_frame_ctrl.sv
// tb_pe_frame_ctrl: directed and randomized frames through pe_frame_ctrl with a
// behavioural pe responder; expectations come from frame-level packing rules and
// handshake timing derived from the pe response delays.
module tb_pe_frame_ctrl;
    localparam int NP = 4;
    localparam int TO = 16;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_r, in_g, in_b;
    logic [8*NP-1:0] pe_red_in, pe_green_in, pe_blue_in;
    logic            Start_Sum, Start_BgRemoval, Ack;
    logic            pe_sum_done, pe_bg_done;
    logic [8*NP-1:0] pe_red_out, pe_green_out, pe_blue_out;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_r, out_g, out_b;
    logic            busy;
    logic            timeout_err;

    pe_frame_ctrl #(.NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .pe_red_in(pe_red_in), .pe_green_in(pe_green_in), .pe_blue_in(pe_blue_in),
        .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
        .pe_sum_done(pe_sum_done), .pe_bg_done(pe_bg_done),
        .pe_red_out(pe_red_out), .pe_green_out(pe_green_out), .pe_blue_out(pe_blue_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fr_r [NP];
    logic [7:0] fr_g [NP];
    logic [7:0] fr_b [NP];
    int  sum_delay  = 3;
    int  bg_delay   = 5;
    bit  sum_hang   = 1'b0;
    int  valid_mode = 0;
    int  ready_mode = 0;
    bit  mon_en     = 1'b0;
    int  sum_cnt, bg_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural pe: done flags rise a fixed number of clocks after each start pulse
    always @(posedge Clk) begin
        if (Reset) begin
            pe_sum_done <= 1'b0;
            pe_bg_done  <= 1'b0;
            sum_cnt     <= 0;
            bg_cnt      <= 0;
        end else begin
            if (Start_Sum && !sum_hang) sum_cnt <= sum_delay - 1;
            else if (sum_cnt == 1) begin pe_sum_done <= 1'b1; sum_cnt <= 0; end
            else if (sum_cnt > 1) sum_cnt <= sum_cnt - 1;
            if (Start_BgRemoval) begin pe_sum_done <= 1'b0; bg_cnt <= bg_delay - 1; end
            else if (bg_cnt == 1) begin pe_bg_done <= 1'b1; bg_cnt <= 0; end
            else if (bg_cnt > 1) bg_cnt <= bg_cnt - 1;
            if (Ack) pe_bg_done <= 1'b0;
        end
    end

    // Handshake exclusivity holds on every cycle
    always @(negedge Clk) begin
        if (mon_en && !Reset) begin
            check("starts_exclusive", 64'(Start_Sum & Start_BgRemoval), 64'(0));
            check("ack_exclusive", 64'(Ack & (Start_Sum | Start_BgRemoval)), 64'(0));
        end
    end

    function automatic logic [8*NP-1:0] pack(input logic [7:0] p [NP]);
        logic [8*NP-1:0] v = '0;
        for (int i = 0; i < NP; i++) v = v | ((8*NP)'(p[i]) << (8 * i));
        return v;
    endfunction

    function automatic bit valid_at(input int step);
        if (valid_mode == 0) return 1'b1;
        if (valid_mode == 1) return !(step == 1 || step == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit ready_at(input int step);
        if (ready_mode == 0) return 1'b1;
        if (ready_mode == 1) return (step % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < NP; i++) begin
            fr_r[i] = 8'($urandom);
            fr_g[i] = 8'($urandom);
            fr_b[i] = 8'($urandom);
            pe_red_out[8*i +: 8]   = 8'($urandom);
            pe_green_out[8*i +: 8] = 8'($urandom);
            pe_blue_out[8*i +: 8]  = 8'($urandom);
        end
        sum_delay = int'($urandom_range(2, 6));
        bg_delay  = int'($urandom_range(2, 6));
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_in_ready_held", 64'(in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_start_sum", 64'(Start_Sum), 64'(0));
        check("rst_start_bg", 64'(Start_BgRemoval), 64'(0));
        check("rst_ack", 64'(Ack), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_pe_red_in", 64'(pe_red_in), 64'(0));
        check("rst_pe_blue_in", 64'(pe_blue_in), 64'(0));
        check("rst_out_r", 64'(out_r), 64'(0));
        Reset = 1'b0;
        #1;
        check("rst_in_ready_idle", 64'(in_ready), 64'(1));
    endtask

    task automatic load_frame();
        int k = 0;
        int step = 0;
        bit v;
        while (k < NP && step < 64) begin
            v = valid_at(step);
            in_valid = v;
            in_r = fr_r[k];
            in_g = fr_g[k];
            in_b = fr_b[k];
            check("load_in_ready", 64'(in_ready), 64'(1));
            check("load_busy", 64'(busy), 64'(k > 0));
            check("load_no_early_start", 64'(Start_Sum), 64'(0));
            @(posedge Clk);
            #1;
            if (v) k++;
            step++;
        end
        in_valid = 1'b0;
        check("load_all_accepted", 64'(k), 64'(NP));
        check("start_sum_after_last", 64'(Start_Sum), 64'(1));
        check("pe_red_in", 64'(pe_red_in), 64'(pack(fr_r)));
        check("pe_green_in", 64'(pe_green_in), 64'(pack(fr_g)));
        check("pe_blue_in", 64'(pe_blue_in), 64'(pack(fr_b)));
    endtask

    task automatic run_pe_and_drain();
        int cyc = 0;
        int idx = 0;
        int guard = 0;
        bit rdy;
        while (cyc < 100 && out_valid !== 1'b1) begin
            @(posedge Clk);
            #1;
            cyc++;
            check("start_sum_single", 64'(Start_Sum), 64'(0));
            check("start_bg_timing", 64'(Start_BgRemoval), 64'(cyc == sum_delay + 1));
            check("ack_timing", 64'(Ack),
                  64'(cyc >= sum_delay + bg_delay + 2 && cyc <= sum_delay + bg_delay + 3));
            check("wait_in_ready", 64'(in_ready), 64'(0));
        end
        check("first_out_latency", 64'(cyc), 64'(sum_delay + bg_delay + 4));
        while (idx < NP && guard < 100) begin
            rdy = ready_at(guard);
            out_ready = rdy;
            check("drain_out_valid", 64'(out_valid), 64'(1));
            check("out_r", 64'(out_r), 64'(pe_red_out[8*idx +: 8]));
            check("out_g", 64'(out_g), 64'(pe_green_out[8*idx +: 8]));
            check("out_b", 64'(out_b), 64'(pe_blue_out[8*idx +: 8]));
            check("drain_in_ready", 64'(in_ready), 64'(0));
            check("drain_busy", 64'(busy), 64'(1));
            @(posedge Clk);
            #1;
            if (rdy) idx++;
            guard++;
        end
        out_ready = 1'b0;
        check("drain_all_pixels", 64'(idx), 64'(NP));
        check("done_out_valid", 64'(out_valid), 64'(0));
        check("done_busy", 64'(busy), 64'(0));
        check("done_in_ready", 64'(in_ready), 64'(1));
        check("pe_red_in_stable", 64'(pe_red_in), 64'(pack(fr_r)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        out_ready = 1'b0;
        rand_frame();
        do_reset();
        mon_en = 1'b1;

        // Known frame: reds 11..44, pe returns reds AA..DD
        fr_r = '{8'h11, 8'h22, 8'h33, 8'h44};
        pe_red_out = 32'hDDCCBBAA;
        sum_delay = 3;
        bg_delay = 5;
        valid_mode = 0;
        ready_mode = 0;
        load_frame();
        check("known_red_pack", 64'(pe_red_in), 64'(32'h44332211));
        run_pe_and_drain();

        // Gapped input valid and stalling output ready
        rand_frame();
        valid_mode = 1;
        ready_mode = 1;
        load_frame();
        run_pe_and_drain();

        // Random frames, gaps and pe delays
        valid_mode = 2;
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            load_frame();
            run_pe_and_drain();
        end

        // pe never reports sum done
        rand_frame();
        valid_mode = 0;
        sum_hang = 1'b1;
        load_frame();
        for (int c = 1; c < TO; c++) begin
            @(posedge Clk);
            #1;
            check("no_early_timeout", 64'(timeout_err), 64'(0));
        end
        @(posedge Clk);
        #1;
        check("timeout_err_set", 64'(timeout_err), 64'(1));
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
            check("err_in_ready", 64'(in_ready), 64'(0));
            check("err_sticky", 64'(timeout_err), 64'(1));
            check("err_busy", 64'(busy), 64'(1));
            check("err_out_valid", 64'(out_valid), 64'(0));
            check("err_ack", 64'(Ack), 64'(0));
        end
        sum_hang = 1'b0;
        do_reset();

        // Reset while waiting for background done
        rand_frame();
        sum_delay = 3;
        bg_delay = 10;
        load_frame();
        for (int c = 0; c < 20 && Start_BgRemoval !== 1'b1; c++) begin
            @(posedge Clk);
            #1;
        end
        check("bg_started_before_reset", 64'(Start_BgRemoval), 64'(1));
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_start_bg", 64'(Start_BgRemoval), 64'(0));
        check("midrst_ack", 64'(Ack), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_timeout_err", 64'(timeout_err), 64'(0));
        check("midrst_pe_green_in", 64'(pe_green_in), 64'(0));
        Reset = 1'b0;
        #1;
        check("midrst_in_ready_after", 64'(in_ready), 64'(1));
        rand_frame();
        ready_mode = 2;
        load_frame();
        run_pe_and_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
